// File: rtl/sfx_queue_player_if.sv
// -----------------------------------------------------------------------------
// sfx_queue_player_if
//
// Command handshake between the judgement logic (master) and the sound-effect
// player (slave).
//
//   i_Cmd        master -> slave  2  0: none, 1: Perfect, 2: Good, 3: Miss
//   i_Cmd_Valid  master -> slave  1  command present this cycle
//   o_Cmd_Ready  slave  -> master 1  player can take the command this cycle
// -----------------------------------------------------------------------------
interface sfx_queue_player_if;
  logic [1:0] i_Cmd;
  logic       i_Cmd_Valid;
  logic       o_Cmd_Ready;

  modport master (
    output i_Cmd,
    output i_Cmd_Valid,
    input  o_Cmd_Ready
  );

  modport slave (
    input  i_Cmd,
    input  i_Cmd_Valid,
    output o_Cmd_Ready
  );
endinterface

// File: rtl/sfx_queue_player.sv
// -----------------------------------------------------------------------------
// sfx_queue_player
//
// Queued multi-note sound-effect generator for the piezo buzzer. Judgement
// commands arrive over a valid/ready handshake and are buffered in a small
// FIFO. Each command is then played as a fixed sequence of square-wave notes,
// followed by a programmable silent gap.
//
//   Perfect (1): two notes (step0, then step1)
//   Good    (2): one note
//   Miss    (3): one note
//
// Ports
//   i_Clk       in   system clock
//   i_Rst_n     in   synchronous active-low reset
//   cmd_if      slave modport: i_Cmd / i_Cmd_Valid / o_Cmd_Ready
//   o_Piezo     out  square-wave buzzer drive (low when not playing)
//   o_Busy      out  player not idle, or commands still queued
//   o_Q_Level   out  FIFO occupancy (registered)
//
// Parameters
//   TONE_W / DUR_W   widths of the half-period and note-duration counters
//   QDEPTH           FIFO depth (power of two, >= 2)
//   GAP_CYC          silent cycles after each effect (0 = no gap)
//   *_HALF / *_DUR   note table in cycles; the defaults are the production
//                    tones at 50 MHz and are only overridden for short runs
//
// Configuration macro
//   SFX_PREEMPT_EN   when defined, a command of higher value than the effect
//                    currently playing (or in its gap) bypasses the FIFO and
//                    restarts playback immediately; the interrupted effect is
//                    dropped and the queue is left untouched.
// -----------------------------------------------------------------------------
module sfx_queue_player #(
  parameter int TONE_W     = 18,
  parameter int DUR_W      = 24,
  parameter int QDEPTH     = 4,
  parameter int GAP_CYC    = 500_000,
  parameter int PERF0_HALF = 23_878,
  parameter int PERF0_DUR  = 3_000_000,
  parameter int PERF1_HALF = 15_944,
  parameter int PERF1_DUR  = 3_000_000,
  parameter int GOOD_HALF  = 47_801,
  parameter int GOOD_DUR   = 4_500_000,
  parameter int MISS_HALF  = 62_500,
  parameter int MISS_DUR   = 8_000_000
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_n,
  sfx_queue_player_if.slave         cmd_if,
  output logic                      o_Piezo,
  output logic                      o_Busy,
  output logic [$clog2(QDEPTH):0]   o_Q_Level
);

  localparam int AW = $clog2(QDEPTH);
  localparam int LW = AW + 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam longint TONE_LIM = longint'(1) << TONE_W;
  localparam longint DUR_LIM  = longint'(1) << DUR_W;

  // A note counter runs 0..N-1, so every table entry N must satisfy
  // 1 <= N <= 2**W for its counter width.
  localparam bit HALF_OK =
    (PERF0_HALF >= 1) && (longint'(PERF0_HALF) <= TONE_LIM) &&
    (PERF1_HALF >= 1) && (longint'(PERF1_HALF) <= TONE_LIM) &&
    (GOOD_HALF  >= 1) && (longint'(GOOD_HALF)  <= TONE_LIM) &&
    (MISS_HALF  >= 1) && (longint'(MISS_HALF)  <= TONE_LIM);
  localparam bit DUR_OK =
    (PERF0_DUR >= 1) && (longint'(PERF0_DUR) <= DUR_LIM) &&
    (PERF1_DUR >= 1) && (longint'(PERF1_DUR) <= DUR_LIM) &&
    (GOOD_DUR  >= 1) && (longint'(GOOD_DUR)  <= DUR_LIM) &&
    (MISS_DUR  >= 1) && (longint'(MISS_DUR)  <= DUR_LIM);

  if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_qdepth
    $error("sfx_queue_player: QDEPTH must be a power of two >= 2");
  end
  if (!HALF_OK) begin : g_bad_half
    $error("sfx_queue_player: half-period table does not fit TONE_W");
  end
  if (!DUR_OK) begin : g_bad_dur
    $error("sfx_queue_player: duration table does not fit DUR_W");
  end
  if (GAP_CYC < 0) begin : g_bad_gap
    $error("sfx_queue_player: GAP_CYC must be >= 0");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Last tone-counter value (HALF-1) for a given command and step.
  function automatic logic [TONE_W-1:0] half_last(input logic [1:0] cmd,
                                                   input logic       step);
    case (cmd)
      2'd1:    half_last = step ? TONE_W'(PERF1_HALF - 1) : TONE_W'(PERF0_HALF - 1);
      2'd2:    half_last = TONE_W'(GOOD_HALF - 1);
      default: half_last = TONE_W'(MISS_HALF - 1);
    endcase
  endfunction

  // Last duration-counter value (DUR-1) for a given command and step.
  function automatic logic [DUR_W-1:0] dur_last(input logic [1:0] cmd,
                                                 input logic       step);
    case (cmd)
      2'd1:    dur_last = step ? DUR_W'(PERF1_DUR - 1) : DUR_W'(PERF0_DUR - 1);
      2'd2:    dur_last = DUR_W'(GOOD_DUR - 1);
      default: dur_last = DUR_W'(MISS_DUR - 1);
    endcase
  endfunction

  state_t              state_q,  state_d;
  logic [1:0]          cmd_q,    cmd_d;
  logic                step_q,   step_d;
  logic [TONE_W-1:0]   tone_q,   tone_d;
  logic [DUR_W-1:0]    dur_q,    dur_d;
  logic [GW-1:0]       gap_q,    gap_d;
  logic                piezo_q,  piezo_d;
  logic [LW-1:0]       count_q,  count_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic                ready_q,  ready_d;
  logic [1:0]          mem_q [QDEPTH];

  logic                preempt;
  logic                push;
  logic                pop;

  // Pre-emption only looks at the command currently owning the buzzer,
  // which is still held in cmd_q during the trailing gap.
`ifdef SFX_PREEMPT_EN
  assign preempt = (state_q != ST_IDLE) && cmd_if.i_Cmd_Valid &&
                   (cmd_if.i_Cmd > cmd_q);
`else
  assign preempt = 1'b0;
`endif

  // Ready is the registered "not full" flag; a pre-empting command is taken
  // regardless of occupancy because it never enters the FIFO.
  assign cmd_if.o_Cmd_Ready = ready_q | preempt;

  // Command 0 completes the handshake but is never stored.
  assign push = cmd_if.i_Cmd_Valid && ready_q && (cmd_if.i_Cmd != 2'd0) && !preempt;

  assign o_Piezo   = piezo_q;
  assign o_Busy    = (state_q != ST_IDLE) || (count_q != '0);
  assign o_Q_Level = count_q;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    step_d  = step_q;
    tone_d  = tone_q;
    dur_d   = dur_q;
    gap_d   = gap_q;
    piezo_d = piezo_q;
    pop     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = ST_PLAY;
          cmd_d   = mem_q[rd_ptr_q];
          step_d  = 1'b0;
          tone_d  = '0;
          dur_d   = '0;
          piezo_d = 1'b0;
        end
      end

      ST_PLAY: begin
        if (tone_q == half_last(cmd_q, step_q)) begin
          tone_d  = '0;
          piezo_d = ~piezo_q;
        end else begin
          tone_d  = tone_q + TONE_W'(1);
        end

        // Note end overrides the tone toggle: every note starts low.
        if (dur_q == dur_last(cmd_q, step_q)) begin
          tone_d  = '0;
          dur_d   = '0;
          piezo_d = 1'b0;
          if (cmd_q == 2'd1 && !step_q) begin
            step_d = 1'b1;
          end else if (GAP_CYC > 0) begin
            state_d = ST_GAP;
            gap_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          dur_d = dur_q + DUR_W'(1);
        end
      end

      ST_GAP: begin
        if (gap_q == GW'(GAP_CYC - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        piezo_d = 1'b0;
      end
    endcase

    if (preempt) begin
      state_d = ST_PLAY;
      cmd_d   = cmd_if.i_Cmd;
      step_d  = 1'b0;
      tone_d  = '0;
      dur_d   = '0;
      piezo_d = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + LW'(1);
    end else if (!push && pop) begin
      count_d = count_q - LW'(1);
    end
    ready_d = (count_d < LW'(QDEPTH));
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q  <= ST_IDLE;
      cmd_q    <= 2'd0;
      step_q   <= 1'b0;
      tone_q   <= '0;
      dur_q    <= '0;
      gap_q    <= '0;
      piezo_q  <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      step_q   <= step_d;
      tone_q   <= tone_d;
      dur_q    <= dur_d;
      gap_q    <= gap_d;
      piezo_q  <= piezo_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ready_d;
    end
  end

  // Storage is plain data: emptiness is tracked by count_q, so no reset.
  always_ff @(posedge i_Clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmd_if.i_Cmd;
    end
  end

endmodule

// File: tb/tb_sfx_queue_player.sv
// -----------------------------------------------------------------------------
// tb_sfx_queue_player
//
// Drives sfx_queue_player with a shortened note table and compares every cycle
// against a reference model: a queue of pending commands plus "which effect,
// which note, how many cycles into it". The expected buzzer level is derived
// from elapsed note time as floor(t / HALF) mod 2.
// -----------------------------------------------------------------------------
module tb_sfx_queue_player;

  localparam int TONE_W = 8;
  localparam int DUR_W  = 10;
  localparam int QDEPTH = 4;
  localparam int GAP    = 7;
  localparam int P0_H = 3, P0_D = 20;
  localparam int P1_H = 2, P1_D = 16;
  localparam int G_H  = 5, G_D  = 30;
  localparam int M_H  = 4, M_D  = 40;
  localparam int LW   = $clog2(QDEPTH) + 1;

`ifdef SFX_PREEMPT_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  localparam int M_IDLE = 0, M_PLAY = 1, M_GAP = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          piezo;
  logic          busy;
  logic [LW-1:0] q_level;

  sfx_queue_player_if ifc ();

  sfx_queue_player #(
    .TONE_W(TONE_W), .DUR_W(DUR_W), .QDEPTH(QDEPTH), .GAP_CYC(GAP),
    .PERF0_HALF(P0_H), .PERF0_DUR(P0_D), .PERF1_HALF(P1_H), .PERF1_DUR(P1_D),
    .GOOD_HALF(G_H), .GOOD_DUR(G_D), .MISS_HALF(M_H), .MISS_DUR(M_D)
  ) dut (
    .i_Clk    (clk),
    .i_Rst_n  (rst_n),
    .cmd_if   (ifc),
    .o_Piezo  (piezo),
    .o_Busy   (busy),
    .o_Q_Level(q_level)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  string phase    = "init";

  // Reference model state
  int m_q[$];
  int m_mode = M_IDLE;
  int m_cur  = 0;
  int m_step = 0;
  int m_j    = 0;
  int m_g    = 0;

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s cycle=%0d got=%0d expected=%0d", phase, tag, cyc, act, exp);
    end
  endtask

  function automatic int half_of(input int c, input int s);
    case (c)
      1:       half_of = (s != 0) ? P1_H : P0_H;
      2:       half_of = G_H;
      default: half_of = M_H;
    endcase
  endfunction

  function automatic int dur_of(input int c, input int s);
    case (c)
      1:       dur_of = (s != 0) ? P1_D : P0_D;
      2:       dur_of = G_D;
      default: dur_of = M_D;
    endcase
  endfunction

  function automatic logic preempt_hit(input logic v, input logic [1:0] c);
    preempt_hit = PRE && (m_mode != M_IDLE) && v && (int'(c) > m_cur);
  endfunction

  function automatic logic exp_ready(input logic v, input logic [1:0] c);
    exp_ready = (m_q.size() < QDEPTH) || preempt_hit(v, c);
  endfunction

  function automatic logic exp_piezo();
    if (m_mode == M_PLAY) exp_piezo = ((m_j / half_of(m_cur, m_step)) % 2) == 1;
    else                  exp_piezo = 1'b0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_mode = M_IDLE;
    m_cur  = 0;
    m_step = 0;
    m_j    = 0;
    m_g    = 0;
  endtask

  task automatic model_start(input int c);
    m_mode = M_PLAY;
    m_cur  = c;
    m_step = 0;
    m_j    = 0;
  endtask

  // Advance the model across one clock edge with the given inputs.
  task automatic model_edge(input logic rn, input logic v, input logic [1:0] c);
    logic pre;
    logic push;
    if (!rn) begin
      model_reset();
    end else begin
      pre  = preempt_hit(v, c);
      push = v && (m_q.size() < QDEPTH) && (c != 2'd0) && !pre;
      case (m_mode)
        M_IDLE: begin
          if (m_q.size() > 0) model_start(m_q.pop_front());
        end
        M_PLAY: begin
          m_j++;
          if (m_j == dur_of(m_cur, m_step)) begin
            if (m_cur == 1 && m_step == 0) begin
              m_step = 1;
              m_j    = 0;
            end else if (GAP > 0) begin
              m_mode = M_GAP;
              m_g    = 0;
            end else begin
              m_mode = M_IDLE;
            end
          end
        end
        default: begin
          m_g++;
          if (m_g == GAP) m_mode = M_IDLE;
        end
      endcase
      if (pre)  model_start(int'(c));
      if (push) m_q.push_back(int'(c));
    end
  endtask

  // One full clock: apply inputs, check the combinational ready, take the
  // edge, then check the registered outputs against the model.
  task automatic step_cycle(input logic rn, input logic v, input logic [1:0] c);
    rst_n           = rn;
    ifc.i_Cmd_Valid = v;
    ifc.i_Cmd       = c;
    #1;
    check_eq("ready", 32'(ifc.o_Cmd_Ready), 32'(exp_ready(v, c)));
    @(posedge clk);
    model_edge(rn, v, c);
    cyc++;
    #1;
    check_eq("piezo", 32'(piezo),   32'(exp_piezo()));
    check_eq("busy",  32'(busy),    32'((m_mode != M_IDLE) || (m_q.size() != 0)));
    check_eq("level", 32'(q_level), 32'(m_q.size()));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step_cycle(1'b1, 1'b0, 2'd0);
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (busy === 1'b1 && n < max_cyc) begin
      step_cycle(1'b1, 1'b0, 2'd0);
      n++;
    end
    check_eq("drain_done", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n           = 1'b0;
    ifc.i_Cmd_Valid = 1'b0;
    ifc.i_Cmd       = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state
    phase = "reset";
    step_cycle(1'b0, 1'b0, 2'd0);
    check_eq("rst_ready", 32'(ifc.o_Cmd_Ready), 32'd1);
    check_eq("rst_level", 32'(q_level), 32'd0);
    check_eq("rst_busy",  32'(busy),    32'd0);
    check_eq("rst_piezo", 32'(piezo),   32'd0);

    // Command 0: accepted and discarded
    phase = "cmd0";
    step_cycle(1'b1, 1'b1, 2'd0);
    check_eq("cmd0_level", 32'(q_level), 32'd0);
    check_eq("cmd0_busy",  32'(busy),    32'd0);
    idle_cycles(3);

    // Single Good: tone, then gap, then idle
    phase = "good";
    step_cycle(1'b1, 1'b1, 2'd2);
    drain(200);

    // Perfect: two notes back to back
    phase = "perfect";
    step_cycle(1'b1, 1'b1, 2'd1);
    drain(200);

    // Five Miss back to back plus a sixth attempt while full
    phase = "miss_burst";
    for (int i = 0; i < 6; i++) step_cycle(1'b1, 1'b1, 2'd3);
    check_eq("burst_full_level", 32'(q_level), 32'd4);
    drain(600);

    // Reset in the middle of a Miss
    phase = "mid_reset";
    step_cycle(1'b1, 1'b1, 2'd3);
    step_cycle(1'b1, 1'b1, 2'd2);
    idle_cycles(13);
    step_cycle(1'b0, 1'b0, 2'd0);
    check_eq("midrst_piezo", 32'(piezo),   32'd0);
    check_eq("midrst_busy",  32'(busy),    32'd0);
    check_eq("midrst_level", 32'(q_level), 32'd0);
    idle_cycles(20);

    // Higher-value command during playback (pre-empts when enabled)
    phase = "preempt";
    step_cycle(1'b1, 1'b1, 2'd2);
    idle_cycles(9);
    step_cycle(1'b1, 1'b1, 2'd3);
    idle_cycles(10);
    step_cycle(1'b1, 1'b1, 2'd1);
    drain(400);

    // Randomised traffic with occasional resets
    phase = "random";
    for (int i = 0; i < 4000; i++) begin
      logic       v;
      logic [1:0] c;
      logic       rn;
      v  = ($urandom_range(0, 7) == 0);
      c  = 2'($urandom_range(0, 3));
      rn = ($urandom_range(0, 1499) != 0);
      step_cycle(rn, v, c);
    end
    phase = "final";
    drain(1000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sfx_queue_player.md
# sfx_queue_player

Queued, multi-note sound-effect generator driving the rhythm game's piezo buzzer. Accepts judgement commands (Perfect/Good/Miss) through a valid/ready handshake, buffers them in a small FIFO, and plays each as a fixed note sequence of square waves with a programmable silent gap between effects. It replaces the single-shot buzzer driver: back-to-back judgements are no longer lost or truncated, and optional priority pre-emption lets a Miss cut in immediately.

## Interface
- TONE_W, 18: width of half-period counter (cycles)
- DUR_W, 24: width of note-duration counter (cycles)
- QDEPTH, 4: command FIFO depth (power of two, ≥2)
- GAP_CYC, 500_000: silent cycles inserted after each effect (0 = no gap)
- i_Clk  in  1  system clock, 50 MHz
- i_Rst_n  in  1  synchronous active-low reset
- i_Cmd  in  2  0: none, 1: Perfect, 2: Good, 3: Miss
- i_Cmd_Valid  in  1  command present
- o_Cmd_Ready  out  1  FIFO can accept
- o_Piezo  out  1  square-wave buzzer drive
- o_Busy  out  1  state ≠ IDLE or FIFO non-empty
- o_Q_Level  out  $clog2(QDEPTH)+1  FIFO occupancy

## Operation
- Note table (half-period HALF / duration DUR, cycles): cmd1 = step0 23_878/3_000_000, step1 15_944/3_000_000; cmd2 = 47_801/4_500_000; cmd3 = 62_500/8_000_000.
- Push when i_Cmd_Valid && o_Cmd_Ready && i_Cmd≠0; i_Cmd=0 with valid is accepted and discarded.
- o_Cmd_Ready = (count < QDEPTH); no full-FIFO pass-through even if a pop occurs the same cycle.
- States: IDLE → PLAY (pop when FIFO non-empty) → next step in PLAY if the sequence has one, else GAP (GAP_CYC>0) or IDLE (GAP_CYC=0); GAP → IDLE after GAP_CYC cycles.
- PLAY: tone counter 0..HALF-1, o_Piezo toggles when counter = HALF-1 and wraps to 0; duration counter 0..DUR-1, note ends when it reaches DUR-1.
- Every note start (including step1 of Perfect) forces o_Piezo=0 and clears the tone counter.
- o_Piezo=0 in IDLE and GAP.
- Counters never exceed TONE_W/DUR_W; table values must fit, and the parameter check fails elaboration otherwise.

## Timing
- Reset (synchronous, takes effect at the first edge with i_Rst_n=0): state IDLE, FIFO empty, o_Piezo=0, o_Busy=0, o_Q_Level=0, o_Cmd_Ready=1; in-progress note aborted.
- Push at edge N into an empty FIFO in IDLE: pop and enter PLAY at edge N+1; first o_Piezo rise at edge N+1+HALF.
- A note occupies exactly DUR cycles in PLAY; next step/GAP entered on the following edge.
- Simultaneous push and pop: o_Q_Level unchanged.
- o_Q_Level and o_Cmd_Ready are registered and reflect occupancy after the current edge.

## Configuration
- SFX_PREEMPT_EN defined: while in PLAY or GAP, a valid command with value greater than the currently playing command (3 > 2 > 1) bypasses the FIFO; o_Cmd_Ready is forced to 1 for it. At the next edge, PLAY restarts at step0 of the new command, and o_Piezo=0. FIFO contents are untouched, and the interrupted effect is dropped. Equal or lower values are queued normally.
- SFX_PREEMPT_EN undefined: strict FIFO order, with no bypass.

## Test plan
- Single Good after reset → o_Piezo period 95_602 cycles for 4_500_000 cycles, then GAP_CYC cycles low, o_Busy falls.
- Perfect → 3_000_000 cycles at half-period 23_878, o_Piezo forced low, then 3_000_000 cycles at 15_944.
- Push 5 Miss commands back-to-back with QDEPTH=4 → 1st pops immediately, next 4 accepted, 6th attempt sees o_Cmd_Ready=0. All 5 play in order, and o_Q_Level counts down 4→0.
- Valid with i_Cmd=0 → accepted, o_Q_Level stays 0, o_Busy stays 0.
- Reset asserted mid-Miss → at the next edge, o_Piezo=0, o_Q_Level=0, and state IDLE; no further output.
- With SFX_PREEMPT_EN: Good playing, Miss arrives → Miss starts next edge with o_Piezo=0. A Perfect arriving during the Miss is queued, and plays after the Miss and its gap.
